// File: rtl/axi4l_regbank_if.sv
// AXI4-Lite bus bundle for the register bank.
// Master drives requests, slave drives readies/responses.
interface axi4l_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    output WDATA, WSTRB, WVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    output RREADY,
    input  AWREADY, WREADY,
    input  BRESP, BVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    input  WDATA, WSTRB, WVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    input  RREADY,
    output AWREADY, WREADY,
    output BRESP, BVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4l_regbank.sv
// AXI4-Lite register bank: RW control regs, RO status
// regs, edge-triggered W1C interrupt block.
module axi4l_regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CTRL   = 4,
  parameter int NUM_STAT   = 2,
  parameter int IRQ_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic ACLK,
  input  logic ARESETN,
  axi4l_regbank_if.slave s,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
  output logic [NUM_CTRL-1:0]            ctrl_wr,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_WIDTH-1:0]
               status_in,
  input  logic [IRQ_WIDTH-1:0]           irq_src,
  output logic                           irq
);

  localparam int SB = DATA_WIDTH / 8;
  localparam int AL = $clog2(SB);

  localparam int unsigned NC  = NUM_CTRL;
  localparam int unsigned NS  = NUM_STAT;
  localparam int unsigned IST = NC + NS;
  localparam int unsigned IEN = NC + NS + 1;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  localparam logic [2:0] K_CTRL = 3'd0;
  localparam logic [2:0] K_STAT = 3'd1;
  localparam logic [2:0] K_IST  = 3'd2;
  localparam logic [2:0] K_IEN  = 3'd3;
  localparam logic [2:0] K_NONE = 3'd4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic int unsigned idx_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return 32'(a >> AL);
  endfunction

  function automatic logic [2:0] kind_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    int unsigned i;
    logic [2:0]  k;
    i = idx_of(a);
    unique case (1'b1)
      (i < NC):             k = K_CTRL;
      (i >= NC && i < IST): k = K_STAT;
      (i == IST):           k = K_IST;
      (i == IEN):           k = K_IEN;
      default:              k = K_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bmask(
    input logic [SB-1:0] st
  );
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < SB; b++) begin
      m[8*b +: 8] = {8{st[b]}};
    end
    return m;
  endfunction

  logic                  en_q;
  logic [1:0]            wst_q, wst_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SB-1:0]         wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_CTRL];
  logic [NUM_CTRL-1:0]   ctrl_wr_q, ctrl_wr_d;
  logic [IRQ_WIDTH-1:0]  ist_q, ist_d;
  logic [IRQ_WIDTH-1:0]  ien_q, ien_d;
  logic [IRQ_WIDTH-1:0]  src_q;
  logic                  irq_q, irq_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data, c_mask;
  logic [SB-1:0]         c_strb;
  logic [2:0]            c_kind;
  int unsigned           c_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic [2:0]            r_kind;
  int unsigned           r_idx;
  logic                  unused_prot;

  assign unused_prot = ^{s.AWPROT, s.ARPROT};

  assign s.AWREADY = en_q &&
    (wst_q == W_IDLE || wst_q == W_HAVE_W);
  assign s.WREADY  = en_q &&
    (wst_q == W_IDLE || wst_q == W_HAVE_AW);
  assign s.BVALID  = (wst_q == W_RESP);
  assign s.BRESP   = bresp_q;
  assign s.ARREADY = en_q && !rvalid_q;
  assign s.RVALID  = rvalid_q;
  assign s.RDATA   = rdata_q;
  assign s.RRESP   = rresp_q;
  assign ctrl_wr   = ctrl_wr_q;
  assign irq       = irq_q;

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_out
    assign ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
  end

  assign aw_hs = s.AWVALID && s.AWREADY;
  assign w_hs  = s.WVALID && s.WREADY;
  assign ar_hs = s.ARVALID && s.ARREADY;

  // Write channel sequencing and commit detection
  always_comb begin
    wst_d    = wst_q;
    commit   = 1'b0;
    awaddr_d = aw_hs ? s.AWADDR : awaddr_q;
    wdata_d  = w_hs ? s.WDATA : wdata_q;
    wstrb_d  = w_hs ? s.WSTRB : wstrb_q;
    case (wst_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          wst_d  = W_RESP;
        end else if (aw_hs) begin
          wst_d = W_HAVE_AW;
        end else if (w_hs) begin
          wst_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit = 1'b1;
          wst_d  = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit = 1'b1;
          wst_d  = W_RESP;
        end
      end
      default: begin
        if (s.BREADY) wst_d = W_IDLE;
      end
    endcase
  end

  // Operands of the committing write
  always_comb begin
    c_addr = (wst_q == W_HAVE_AW) ? awaddr_q : s.AWADDR;
    c_data = (wst_q == W_HAVE_W) ? wdata_q : s.WDATA;
    c_strb = (wst_q == W_HAVE_W) ? wstrb_q : s.WSTRB;
    c_mask = bmask(c_strb);
    c_kind = kind_of(c_addr);
    c_idx  = idx_of(c_addr);
  end

  // Register updates caused by a committed write
  always_comb begin
    ctrl_wr_d = '0;
    bresp_d   = bresp_q;
    ien_d     = ien_q;
    ist_d     = ist_q;
    for (int unsigned k = 0; k < NC; k++) begin
      ctrl_d[k] = ctrl_q[k];
    end
    if (commit) begin
      bresp_d = (c_kind == K_NONE) ? SLVERR : OKAY;
      for (int unsigned k = 0; k < NC; k++) begin
        if (c_kind == K_CTRL && c_idx == k) begin
          ctrl_d[k] = (ctrl_q[k] & ~c_mask)
                    | (c_data & c_mask);
          ctrl_wr_d[k] = 1'b1;
        end
      end
      if (c_kind == K_IEN) begin
        ien_d = (ien_q & ~c_mask[IRQ_WIDTH-1:0])
              | (c_data[IRQ_WIDTH-1:0]
                 & c_mask[IRQ_WIDTH-1:0]);
      end
      if (c_kind == K_IST) begin
        ist_d = ist_q & ~(c_data[IRQ_WIDTH-1:0]
                          & c_mask[IRQ_WIDTH-1:0]);
      end
    end
    ist_d = ist_d | (irq_src & ~src_q);
    irq_d = |(ist_q & ien_q);
  end

  // Read data mux, evaluated at the AR handshake
  always_comb begin
    r_kind  = kind_of(s.ARADDR);
    r_idx   = idx_of(s.ARADDR);
    rd_data = '0;
    rd_resp = OKAY;
    unique case (1'b1)
      (r_kind == K_CTRL): begin
        for (int unsigned k = 0; k < NC; k++) begin
          if (r_idx == k) rd_data = ctrl_q[k];
        end
      end
      (r_kind == K_STAT): begin
        for (int unsigned j = 0; j < NS; j++) begin
          if (r_idx == NC + j) begin
            rd_data = status_in[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      (r_kind == K_IST): rd_data[IRQ_WIDTH-1:0] = ist_q;
      (r_kind == K_IEN): rd_data[IRQ_WIDTH-1:0] = ien_q;
      default:           rd_resp = SLVERR;
    endcase
  end

  // Read channel: capture on AR, hold until RREADY
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_resp;
    end else if (rvalid_q && s.RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q      <= 1'b0;
      wst_q     <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      ctrl_wr_q <= '0;
      ist_q     <= '0;
      ien_q     <= '0;
      src_q     <= '0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= CTRL_RESET;
      end
    end else begin
      en_q      <= 1'b1;
      wst_q     <= wst_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      ctrl_wr_q <= ctrl_wr_d;
      ist_q     <= ist_d;
      ien_q     <= ien_d;
      src_q     <= irq_src;
      irq_q     <= irq_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// Directed plus randomized bench for axi4l_regbank
// against a register-map reference model.
module tb_axi4l_regbank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ctrl_out;
  logic [3:0]   ctrl_wr;
  logic [63:0]  status_in;
  logic [7:0]   irq_src;
  logic         irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] ctrl_m [4];
  logic [7:0]  ist_m;
  logic [7:0]  ien_m;

  always #5 clk = ~clk;

  axi4l_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus();

  axi4l_regbank dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .s         (bus),
    .ctrl_out  (ctrl_out),
    .ctrl_wr   (ctrl_wr),
    .status_in (status_in),
    .irq_src   (irq_src),
    .irq       (irq)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bm(input logic [3:0] st);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{st[b]}};
    return m;
  endfunction

  task automatic mdl_write(input logic [7:0] addr,
                           input logic [31:0] data,
                           input logic [3:0] strb,
                           output logic [1:0] resp,
                           output logic [3:0] pulse);
    int idx;
    logic [31:0] m;
    idx = int'(addr >> 2);
    m = bm(strb);
    resp = 2'b00;
    pulse = 4'b0;
    if (idx < 4) begin
      ctrl_m[idx] = (ctrl_m[idx] & ~m) | (data & m);
      pulse[idx] = 1'b1;
    end else if (idx < 6) begin
      resp = 2'b00;
    end else if (idx == 6) begin
      ist_m = ist_m & ~(data[7:0] & m[7:0]);
    end else if (idx == 7) begin
      ien_m = (ien_m & ~m[7:0]) | (data[7:0] & m[7:0]);
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic mdl_read(input logic [7:0] addr,
                          output logic [31:0] data,
                          output logic [1:0] resp);
    int idx;
    idx = int'(addr >> 2);
    resp = 2'b00;
    data = 32'h0;
    if (idx < 4) data = ctrl_m[idx];
    else if (idx < 6) data = status_in[(idx-4)*32 +: 32];
    else if (idx == 6) data = {24'h0, ist_m};
    else if (idx == 7) data = {24'h0, ien_m};
    else resp = 2'b10;
  endtask

  task automatic do_write(input logic [7:0] addr,
                          input logic [31:0] data,
                          input logic [3:0] strb,
                          input int aw_dly,
                          input int w_dly,
                          input int b_dly,
                          output logic [1:0] resp,
                          output logic [3:0] pulse);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_now, w_now;
    int t = 0;
    bus.AWADDR = addr;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    while (!(aw_done && w_done) && t < 40) begin
      if (aw_done) chk("awready_hold", bus.AWREADY, 0);
      if (w_done)  chk("wready_hold", bus.WREADY, 0);
      bus.AWVALID = !aw_done && t >= aw_dly;
      bus.WVALID  = !w_done && t >= w_dly;
      aw_now = bus.AWVALID && bus.AWREADY;
      w_now  = bus.WVALID && bus.WREADY;
      tick();
      if (aw_now) aw_done = 1;
      if (w_now)  w_done = 1;
      t++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    chk("wr_accept", {aw_done, w_done}, 2'b11);
    chk("bvalid_rise", bus.BVALID, 1);
    resp  = bus.BRESP;
    pulse = ctrl_wr;
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("bvalid_hold", bus.BVALID, 1);
      chk("bresp_hold", bus.BRESP, resp);
      chk("ctrl_wr_once", ctrl_wr, 0);
      chk("no_aw_in_resp", bus.AWREADY, 0);
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    chk("bvalid_drop", bus.BVALID, 0);
  endtask

  task automatic do_read(input logic [7:0] addr,
                         input int r_dly,
                         output logic [31:0] data,
                         output logic [1:0] resp);
    int t = 0;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && t < 20) begin
      tick();
      t++;
    end
    chk("arready_wait", bus.ARREADY, 1);
    tick();
    bus.ARVALID = 1'b0;
    chk("rvalid_rise", bus.RVALID, 1);
    data = bus.RDATA;
    resp = bus.RRESP;
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk("rdata_hold", bus.RDATA, data);
      chk("rvalid_hold", bus.RVALID, 1);
      chk("arready_low", bus.ARREADY, 0);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    chk("rvalid_drop", bus.RVALID, 0);
  endtask

  task automatic chk_ctrl(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk(tag, ctrl_out[k*32 +: 32], ctrl_m[k]);
    end
  endtask

  task automatic wr_chk(input logic [7:0] addr,
                        input logic [31:0] data,
                        input logic [3:0] strb,
                        input int awd, input int wd,
                        input int bd);
    logic [1:0] r, er;
    logic [3:0] p, ep;
    mdl_write(addr, data, strb, er, ep);
    do_write(addr, data, strb, awd, wd, bd, r, p);
    chk("bresp", r, er);
    chk("ctrl_wr", p, ep);
    chk_ctrl("ctrl_out");
  endtask

  task automatic rd_chk(input logic [7:0] addr,
                        input int rd);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    mdl_read(addr, ed, er);
    do_read(addr, rd, d, r);
    chk("rdata", d, ed);
    chk("rresp", r, er);
  endtask

  initial begin
    logic [1:0] r;
    logic [3:0] p;
    rst_n = 1'b0;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    status_in = 64'h1234_5678_9ABC_DEF0;
    irq_src = 8'h0;
    for (int k = 0; k < 4; k++) ctrl_m[k] = 32'h0;
    ist_m = 8'h0;
    ien_m = 8'h0;
    tick();
    tick();

    chk("rst_awready", bus.AWREADY, 0);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_bresp", bus.BRESP, 0);
    chk("rst_rresp", bus.RRESP, 0);
    chk("rst_rdata", bus.RDATA, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ctrl_wr", ctrl_wr, 0);
    chk_ctrl("rst_ctrl");
    rst_n = 1'b1;
    tick();
    chk("rel_awready", bus.AWREADY, 1);
    chk("rel_wready", bus.WREADY, 1);
    chk("rel_arready", bus.ARREADY, 1);

    for (int k = 0; k < 4; k++) begin
      wr_chk(8'(4*k), 32'(k+1), 4'hF, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) rd_chk(8'(4*k), k % 2);
    rd_chk(8'h10, 0);
    rd_chk(8'h14, 1);

    wr_chk(8'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    wr_chk(8'h00, 32'h11223344, 4'b0101, 0, 0, 0);
    chk("strobe_slice", ctrl_out[31:0], 32'hAA22CC44);
    rd_chk(8'h00, 0);
    wr_chk(8'h04, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);

    wr_chk(8'h08, 32'hCAFE0001, 4'hF, 3, 0, 0);
    wr_chk(8'h0C, 32'hBEEF0002, 4'hF, 0, 3, 5);
    rd_chk(8'h08, 2);
    rd_chk(8'h0C, 0);

    wr_chk(8'h20, 32'hDEADBEEF, 4'hF, 1, 0, 1);
    rd_chk(8'h20, 0);
    wr_chk(8'h10, 32'h5555AAAA, 4'hF, 0, 0, 0);
    rd_chk(8'h10, 0);

    wr_chk(8'h1C, 32'h0000_0001, 4'hF, 0, 0, 0);
    irq_src = 8'h01;
    tick();
    chk("irq_lat1", irq, 0);
    tick();
    chk("irq_lat2", irq, 1);
    ist_m = 8'h01;
    rd_chk(8'h18, 0);
    wr_chk(8'h18, 32'h0000_0001, 4'hF, 0, 0, 0);
    chk("irq_w1c", irq, 0);
    rd_chk(8'h18, 0);
    irq_src = 8'h00;
    tick();
    tick();
    irq_src = 8'h01;
    tick();
    tick();
    chk("irq_reset", irq, 1);
    ist_m = 8'h01;
    irq_src = 8'h00;
    tick();
    tick();
    irq_src = 8'h01;
    wr_chk(8'h18, 32'h0000_0001, 4'hF, 0, 0, 0);
    ist_m = ist_m | 8'h01;
    chk("irq_set_wins", irq, 1);
    rd_chk(8'h18, 0);
    wr_chk(8'h1C, 32'h0000_0300, 4'hF, 0, 0, 0);
    chk("irq_masked", irq, 0);
    rd_chk(8'h1C, 0);
    irq_src = 8'h00;
    tick();

    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      a = 8'({$urandom_range(0, 9), 2'($urandom)});
      status_in = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        wr_chk(a, $urandom, 4'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 2));
      end else begin
        rd_chk(a, $urandom_range(0, 2));
      end
      chk("irq_model", irq, |(ist_m & ien_m));
    end

    wr_chk(8'h00, 32'h0000_0055, 4'hF, 0, 0, 0);
    bus.AWADDR  = 8'h04;
    bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("mid_have_aw", bus.AWREADY, 0);
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) ctrl_m[k] = 32'h0;
    ist_m = 8'h0;
    ien_m = 8'h0;
    chk("mid_bvalid", bus.BVALID, 0);
    chk("mid_awready", bus.AWREADY, 0);
    chk_ctrl("mid_ctrl");
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_awready", bus.AWREADY, 1);
    chk("mid_rel_wready", bus.WREADY, 1);
    chk("mid_rel_bvalid", bus.BVALID, 0);
    rd_chk(8'h1C, 0);
    rd_chk(8'h04, 0);
    wr_chk(8'h04, 32'h0000_00A5, 4'b0001, 0, 0, 0);
    p = ctrl_wr;
    r = bus.BRESP;
    chk("post_quiet", {r, p}, 6'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4l_regbank.md
Name: axi4l_regbank

Overview:
- Parametrised AXI4-Lite slave register bank. It is the generalised successor of the fixed 4-register slave front-end used by the codec I2C/I2S IP.
- Provides NUM_CTRL read/write control registers with byte strobes and NUM_STAT read-only status registers.
- Provides an edge-triggered interrupt block with write-1-to-clear status, a per-source enable mask and a single interrupt output.
- Sits between the AXI interconnect and codec datapath logic (I2C master, I2S serialisers).

Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- ADDR_WIDTH, 8, AXI byte-address width.
- NUM_CTRL, 4, number of RW control registers; 1..32.
- NUM_STAT, 2, number of RO status registers; 0..16.
- IRQ_WIDTH, 8, number of interrupt sources; 1..DATA_WIDTH.
- CTRL_RESET, 0, reset value of every control register.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- ctrl_out  out  NUM_CTRL*DATA_WIDTH  control register contents; reg k occupies slice k.
- ctrl_wr  out  NUM_CTRL  one-cycle pulse per control register written.
- status_in  in  NUM_STAT*DATA_WIDTH  status values, sampled at read.
- irq_src  in  IRQ_WIDTH  level interrupt sources, synchronous to ACLK.
- irq  out  1  registered interrupt output.

Behaviour:
- Addressing: word index = ADDR >> log2(DATA_WIDTH/8); low address bits are ignored.
  - Index 0..NUM_CTRL-1: CTRL registers.
  - Next NUM_STAT indices: STATUS registers.
  - Next index: IRQ_STAT.
  - Next index: IRQ_EN.
  - Any other index is unmapped.
- Reset (asynchronous, ARESETN=0), all values:
  - AWREADY=0, WREADY=0, ARREADY=0, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, irq=0, ctrl_wr=0.
  - Every control register = CTRL_RESET; IRQ_STAT=0; IRQ_EN=0; edge-detect history=0.
- Reset applied mid-transaction drops that transaction with no response. The ready outputs reassert in the first cycle after ARESETN deasserts.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY=1 in W_IDLE and W_HAVE_W. WREADY=1 in W_IDLE and W_HAVE_AW.
  - W_IDLE: AW and W both handshake in the same cycle -> commit -> W_RESP. AW only -> latch address -> W_HAVE_AW. W only -> latch data and strobes -> W_HAVE_W.
  - W_HAVE_AW: W handshake -> commit -> W_RESP. W_HAVE_W: AW handshake -> commit -> W_RESP.
  - Commit occurs on the clock edge of the completing handshake. BVALID=1 from the next cycle and is held, together with BRESP, until BREADY=1. Then -> W_IDLE, with ready outputs high again the following cycle.
  - Only one write is outstanding at a time.
- Write effects at commit:
  - CTRL: update only the bytes whose WSTRB bit is 1. ctrl_wr[k]=1 for exactly one cycle, coincident with the first cycle of BVALID, even when WSTRB=0.
  - IRQ_EN: byte-strobed write; bits at or above IRQ_WIDTH read as 0.
  - IRQ_STAT: write-1-to-clear on strobed bytes.
  - STATUS: write is ignored, BRESP=OKAY.
  - Unmapped: write is ignored, BRESP=SLVERR (2'b10). All mapped writes return OKAY.
- Read FSM:
  - ARREADY=1 only while RVALID=0.
  - On an AR handshake, RDATA/RRESP are registered and RVALID=1 next cycle. They are held stable until RREADY=1; ARREADY returns the cycle after.
  - Unmapped read: RDATA=0, RRESP=SLVERR.
  - STATUS data is sampled on the AR handshake edge.
  - Read and write channels operate independently and concurrently.
- Interrupts:
  - IRQ_STAT[i] sets on a rising edge of irq_src[i] (current=1, previous=0).
  - A set and a W1C clear of the same bit in the same cycle: set wins.
  - irq is a register: irq <= |(IRQ_STAT & IRQ_EN), updated every cycle.
  - Latency from irq_src edge to irq high is 2 cycles when enabled.
- DATA_WIDTH=64: WSTRB is 8 bits and word index = ADDR>>3. Behaviour is otherwise identical.

Test Plan:
- Defaults, write/read every control register: write 0x1,0x2,0x3,0x4 to addr 0x0,0x4,0x8,0xC, then read back -> RDATA matches, RRESP=OKAY, ctrl_wr pulses once per write.
- Byte strobes: reg0=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> reads 0xAA22CC44; ctrl_out slice 0 equals 0xAA22CC44.
- AW/W ordering and backpressure: W 3 cycles before AW, then AW 3 cycles before W, then BREADY held low 5 cycles -> both writes commit; BVALID/BRESP stable until BREADY; no second AW is accepted meanwhile.
- Unmapped access: write and read at index NUM_CTRL+NUM_STAT+2 (addr 0x20 with defaults) -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, control registers unchanged.
- Interrupt: IRQ_EN=0x01, irq_src[0] 0->1 -> irq=1 two cycles later. Write 0x01 to IRQ_STAT -> irq=0. If that write coincides with a new rising edge of irq_src[0], the bit stays set and irq stays 1.
- Reset mid-write: AW accepted, ARESETN pulsed low before W -> BVALID=0, regs=CTRL_RESET, AWREADY=WREADY=1 one cycle after release.
